// File: rtl/imm_field_decoder.sv
// Immediate-path front end: classifies RV32I instruction words by opcode and slices
// immediate fields into a registered 2-entry skid buffer with an illegal-opcode counter.
module imm_field_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output logic [1:0]       extend_o,
  output logic [19:0]      u_type_o,
  output logic [8:0]       j_type_o,
  output logic [12:0]      b_type_o,
  output logic [11:0]      i_and_s_type_o,
  output logic             illegal_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    logic [1:0]  extend;
    logic [19:0] u_type;
    logic [8:0]  j_type;
    logic [12:0] b_type;
    logic [11:0] is_type;
    logic        illegal;
  } fields_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic fields_t decode(input logic [31:0] instr);
    fields_t f;
    f        = '0;
    f.extend = 2'b11;
    case (instr[6:0])
      7'b0110111, 7'b0010111: begin
        f.extend = 2'b00;
        f.u_type = instr[31:12];
      end
      7'b1101111: begin
        f.extend = 2'b01;
        f.j_type = {instr[31], instr[19:12]};
      end
      7'b1100011: begin
        f.extend = 2'b10;
        f.b_type = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0010011, 7'b0000011, 7'b1100111: f.is_type = instr[31:20];
      7'b0100011: f.is_type = {instr[31:25], instr[11:7]};
      7'b0110011: ;
      default: f.illegal = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  // Stage p0: combinational decode of the incoming word
  fields_t dec_p0;
  logic    accept;
  logic    out_xfer;

  assign dec_p0   = decode(instr_i);
  assign accept   = instr_valid_i && instr_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  state_t  state;
  state_t  state_nxt;
  logic    load_main_new;
  logic    load_main_skid;
  logic    load_skid;

  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt     = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (out_xfer && accept) begin
          load_main_new = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: main entry drives the outputs, skid catches the word accepted under stall
  fields_t main_p1;
  fields_t skid_p1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= EMPTY;
      instr_ready_o <= 1'b1;
      out_valid_o   <= 1'b0;
      illegal_cnt_o <= '0;
      main_p1       <= '0;
    end else begin
      state         <= state_nxt;
      instr_ready_o <= (state_nxt != TWO);
      out_valid_o   <= (state_nxt != EMPTY);
      if (accept && dec_p0.illegal) illegal_cnt_o <= sat_inc(illegal_cnt_o);
      if (load_main_new) main_p1 <= dec_p0;
      else if (load_main_skid) main_p1 <= skid_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_skid) skid_p1 <= dec_p0;
  end

  assign extend_o       = main_p1.extend;
  assign u_type_o       = main_p1.u_type;
  assign j_type_o       = main_p1.j_type;
  assign b_type_o       = main_p1.b_type;
  assign i_and_s_type_o = main_p1.is_type;
  assign illegal_o      = main_p1.illegal;

endmodule

// File: tb/tb_imm_field_decoder.sv
// Randomized scoreboard bench for imm_field_decoder; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_imm_field_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [1:0]  extend_o;
  logic [19:0] u_type_o;
  logic [8:0]  j_type_o;
  logic [12:0] b_type_o;
  logic [11:0] i_and_s_type_o;
  logic        illegal_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] illegal_cnt_o;

  logic        ready2;
  logic [1:0]  extend2;
  logic [19:0] u2;
  logic [8:0]  j2;
  logic [12:0] b2;
  logic [11:0] is2;
  logic        illegal2;
  logic        valid2;
  logic [1:0]  cnt2;

  always #5 clk_i = ~clk_i;

  imm_field_decoder #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .extend_o(extend_o), .u_type_o(u_type_o),
    .j_type_o(j_type_o), .b_type_o(b_type_o), .i_and_s_type_o(i_and_s_type_o),
    .illegal_o(illegal_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .illegal_cnt_o(illegal_cnt_o)
  );

  imm_field_decoder #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(ready2), .extend_o(extend2), .u_type_o(u2),
    .j_type_o(j2), .b_type_o(b2), .i_and_s_type_o(is2),
    .illegal_o(illegal2), .out_valid_o(valid2), .out_ready_i(out_ready_i),
    .illegal_cnt_o(cnt2)
  );

  typedef struct {
    int unsigned ext;
    int unsigned u;
    int unsigned j;
    int unsigned b;
    int unsigned is;
    int unsigned ill;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  bit   started   = 0;

  function automatic int unsigned bits(input int unsigned w, input int lo, input int n);
    return (w >> lo) & ((1 << n) - 1);
  endfunction

  // Reference: the immediate slices written as shift/mask arithmetic on the word
  function automatic exp_t ref_decode(input int unsigned w);
    exp_t e;
    int unsigned op;
    e  = '{ext: 3, u: 0, j: 0, b: 0, is: 0, ill: 0};
    op = bits(w, 0, 7);
    if (op == 'h37 || op == 'h17) begin
      e.ext = 0; e.u = bits(w, 12, 20);
    end else if (op == 'h6F) begin
      e.ext = 1; e.j = bits(w, 31, 1) * 256 + bits(w, 12, 8);
    end else if (op == 'h63) begin
      e.ext = 2;
      e.b = bits(w, 31, 1) * 4096 + bits(w, 7, 1) * 2048 + bits(w, 25, 6) * 32 + bits(w, 8, 4) * 2;
    end else if (op == 'h13 || op == 'h03 || op == 'h67) begin
      e.is = bits(w, 20, 12);
    end else if (op == 'h23) begin
      e.is = bits(w, 25, 7) * 32 + bits(w, 7, 5);
    end else if (op != 'h33) begin
      e.ill = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT behaves as a 2-deep FIFO of decoded words
  always @(negedge clk_i) begin
    if (started) begin
      chk("out_valid", out_valid_o, exp_q.size() != 0);
      chk("instr_ready", instr_ready_o, exp_q.size() < 2);
      chk("cnt16", illegal_cnt_o, (model_cnt > 65535) ? 65535 : model_cnt);
      chk("cnt_sat", cnt2, (model_cnt > 3) ? 3 : model_cnt);
      if (out_valid_o && exp_q.size() > 0) begin
        chk("extend", extend_o, exp_q[0].ext);
        chk("u_type", u_type_o, exp_q[0].u);
        chk("j_type", j_type_o, exp_q[0].j);
        chk("b_type", b_type_o, exp_q[0].b);
        chk("i_s_type", i_and_s_type_o, exp_q[0].is);
        chk("illegal", illegal_o, exp_q[0].ill);
      end
      if (rst_ni) begin
        if (out_valid_o && out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (instr_valid_i && instr_ready_o) begin
          exp_t e;
          e = ref_decode(instr_i);
          exp_q.push_back(e);
          if (e.ill != 0) model_cnt++;
        end
      end else begin
        exp_q.delete();
        model_cnt = 0;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    bit acc;
    instr_i       = w;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = instr_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: instr 0x%08h not accepted within 50 cycles", w);
  endtask

  task automatic idle(input int n);
    instr_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_ready", instr_ready_o, 1);
    chk("rst_cnt", illegal_cnt_o, 0);
    chk("rst_extend", extend_o, 0);
    chk("rst_fields", {u_type_o, j_type_o, b_type_o, i_and_s_type_o}, 0);
    chk("rst_illegal", illegal_o, 0);
  endtask

  logic [31:0] ops [10] = '{32'h37, 32'h17, 32'h6F, 32'h63, 32'h13,
                            32'h03, 32'h67, 32'h23, 32'h33, 32'h7F};

  initial begin
    logic [31:0] r;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    started = 1;
    #1;
    check_reset_state();
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;

    send(32'h123450B7);
    send(32'hFFF00093);
    send(32'h0020A423);
    send(32'hFE000EE3);
    idle(3);

    // Back-to-back burst with the consumer stalled for three cycles
    send(32'h000010B7);
    out_ready_i = 1'b0;
    fork
      begin
        send(32'h00C000EF);
        send(32'h00208663);
        send(32'h00412083);
      end
      begin
        repeat (3) begin
          @(posedge clk_i);
          #1;
        end
        out_ready_i = 1'b1;
      end
    join
    idle(4);

    repeat (3) send(32'h0000007F);
    idle(2);
    chk("cnt_after_3", illegal_cnt_o, 3);
    repeat (2) send(32'h0000007F);
    idle(2);

    // Reset while both buffer entries are occupied
    out_ready_i = 1'b0;
    send(32'h00500093);
    send(32'h00600113);
    instr_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check_reset_state();
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    idle(4);

    for (int c = 0; c < 2000; c++) begin
      r             = $urandom();
      instr_i       = {r[31:7], ops[$urandom_range(0, 9)][6:0]};
      if ($urandom_range(0, 7) == 0) instr_i[6:0] = 7'($urandom());
      instr_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i   = ($urandom_range(0, 3) != 0);
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
